// File: rtl/usr_burst_shifter_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the burst shifter slice:
//   - SEL_* : 3-bit operation-mode encodings carried on 'select'
//   - state_e : burst engine states (ST_IDLE, ST_BURST)
//   - is_shift_mode() : true for the modes a burst is allowed to repeat
// ---------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] SEL_HOLD = 3'b000;
    localparam logic [2:0] SEL_SHR  = 3'b001;
    localparam logic [2:0] SEL_SHL  = 3'b010;
    localparam logic [2:0] SEL_LOAD = 3'b011;
    localparam logic [2:0] SEL_ROTR = 3'b100;
    localparam logic [2:0] SEL_ROTL = 3'b101;
    localparam logic [2:0] SEL_ASR  = 3'b110;
    localparam logic [2:0] SEL_ZERO = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Only modes that move bits around are worth repeating; hold, load and
    // zero give the same result after one step, so they never start a burst.
    function automatic logic is_shift_mode(input logic [2:0] sel);
        return (sel == SEL_SHR)  || (sel == SEL_SHL) || (sel == SEL_ROTR) ||
               (sel == SEL_ROTL) || (sel == SEL_ASR);
    endfunction

endpackage

// File: rtl/usr_burst_shifter_if.sv
// ---------------------------------------------------------------------------
// usr_burst_shifter_if
// Groups the data/control bus of the burst shifter.
//   master : drives data_in, select, MSB_in, LSB_in, start, count;
//            observes data_out, MSB_out, LSB_out, busy, done (and parity)
//   slave  : the shifter itself, the opposite directions
// Optional: USR_PARITY_EN adds the 'parity' signal (XOR of data_out).
// ---------------------------------------------------------------------------
interface usr_burst_shifter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] data_in;
    logic [2:0]       select;
    logic             MSB_in;
    logic             LSB_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data_out;
    logic             MSB_out;
    logic             LSB_out;
    logic             busy;
    logic             done;
`ifdef USR_PARITY_EN
    logic             parity;
`endif

    modport master (
`ifdef USR_PARITY_EN
        input  parity,
`endif
        output data_in, select, MSB_in, LSB_in, start, count,
        input  data_out, MSB_out, LSB_out, busy, done
    );

    modport slave (
`ifdef USR_PARITY_EN
        output parity,
`endif
        input  data_in, select, MSB_in, LSB_in, start, count,
        output data_out, MSB_out, LSB_out, busy, done
    );

endinterface

// File: rtl/usr_burst_shifter_step.sv
// ---------------------------------------------------------------------------
// usr_step
// Purely combinational next-value function of the shift register.
//   mode_i : operation mode (SEL_* encoding)
//   cur_i  : current register contents
//   msb_i  : serial bit entering the MSB on a logical right shift
//   lsb_i  : serial bit entering the LSB on a left shift
//   data_i : parallel load value
//   next_o : value the register takes at the next edge
// ---------------------------------------------------------------------------
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] cur_i,
    input  logic             msb_i,
    input  logic             lsb_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o
);

    // One mode-indexed mux; the arithmetic shift keeps the sign bit by
    // feeding the old MSB back into itself.
    always_comb begin
        next_o = cur_i;
        case (mode_i)
            SEL_HOLD: next_o = cur_i;
            SEL_SHR:  next_o = {msb_i, cur_i[WIDTH-1:1]};
            SEL_SHL:  next_o = {cur_i[WIDTH-2:0], lsb_i};
            SEL_LOAD: next_o = data_i;
            SEL_ROTR: next_o = {cur_i[0], cur_i[WIDTH-1:1]};
            SEL_ROTL: next_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
            SEL_ASR:  next_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
            SEL_ZERO: next_o = '0;
            default:  next_o = cur_i;
        endcase
    end

endmodule

// File: rtl/usr_burst_shifter.sv
// ---------------------------------------------------------------------------
// usr_burst_shifter
// Parametrised universal shift register with a counted burst engine.
// A start pulse with a shift-class select repeats that mode 'count' times,
// raising busy while further steps remain and pulsing done for one cycle
// after the final step.
// Ports:
//   CLK   : system clock, rising edge
//   clear : synchronous active-high reset (overrides everything)
//   bus   : usr_burst_shifter_if slave (data_in, select, MSB_in, LSB_in,
//           start, count -> data_out, MSB_out, LSB_out, busy, done)
// Optional: define USR_PARITY_EN to add a registered parity output.
// ---------------------------------------------------------------------------
module usr_burst_shifter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  CLK,
    input  logic                  clear,
    usr_burst_shifter_if.slave    bus
);

    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic [2:0]       stepMode;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i (stepMode),
        .cur_i  (data_q),
        .msb_i  (bus.MSB_in),
        .lsb_i  (bus.LSB_in),
        .data_i (bus.data_in),
        .next_o (data_d)
    );

    // Next-state logic. In IDLE the select input drives the step directly
    // unless a burst is being launched; the first burst step happens on the
    // launching edge, so 'remaining' counts the steps still to come. A zero
    // count start only acknowledges with done. In BURST the latched mode is
    // replayed and all request inputs are ignored.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        stepMode    = SEL_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.count == '0)) begin
                    done_d = 1'b1;
                end else if (bus.start && is_shift_mode(bus.select)) begin
                    stepMode    = bus.select;
                    mode_d      = bus.select;
                    remaining_d = bus.count - CNT_W'(1);
                    if (remaining_d != '0) begin
                        state_d = ST_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    stepMode = bus.select;
                end
            end
            ST_BURST: begin
                stepMode    = mode_q;
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; clear wins over any burst in flight.
    always_ff @(posedge CLK) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            mode_q      <= SEL_HOLD;
            remaining_q <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;

    // Parity is computed from the incoming value so it lines up with data_out.
    always_ff @(posedge CLK) begin
        if (clear) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign bus.parity = parity_q;
`endif

    assign bus.data_out = data_q;
    assign bus.MSB_out  = data_q[WIDTH-1];
    assign bus.LSB_out  = data_q[0];
    assign bus.busy     = (state_q == ST_BURST);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_usr_burst_shifter.sv
// ---------------------------------------------------------------------------
// tb_usr_burst_shifter
// Self-checking bench for usr_burst_shifter (WIDTH=8, CNT_W=4). Expected
// register values come from refStep, an arithmetic description of each mode.
// ---------------------------------------------------------------------------
module tb_usr_burst_shifter;

    localparam int W = 8;
    localparam int C = 4;

    logic CLK = 1'b0;
    logic clear;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp;

    usr_burst_shifter_if #(.WIDTH(W), .CNT_W(C)) bus ();

    usr_burst_shifter #(.WIDTH(W), .CNT_W(C)) dut (
        .CLK   (CLK),
        .clear (clear),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Reference: each mode written as plain integer arithmetic on 0..255.
    function automatic logic [7:0] refStep(input logic [2:0] m, input logic [7:0] v,
                                           input logic mi, input logic li, input logic [7:0] d);
        int x;
        int vi;
        vi = int'(v);
        case (m)
            3'd1:    x = (vi / 2) + (mi ? 128 : 0);
            3'd2:    x = ((vi * 2) % 256) + (li ? 1 : 0);
            3'd3:    x = int'(d);
            3'd4:    x = (vi / 2) + ((vi % 2) * 128);
            3'd5:    x = ((vi * 2) % 256) + (vi / 128);
            3'd6:    x = (vi / 2) + ((vi >= 128) ? 128 : 0);
            3'd7:    x = 0;
            default: x = vi;
        endcase
        return x[7:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        bus.start  = 1'b0;
        bus.select = 3'b000;
        bus.count  = '0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        bus.data_in = 8'h5C; bus.select = 3'b011; bus.start = 1'b1; bus.count = 4'd3;
        bus.MSB_in = 1'b1; bus.LSB_in = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== 10'h000) begin
            bad++;
            $display("[TB] FAIL reset got data=%h busy=%b done=%b want 00/0/0", bus.data_out, bus.busy, bus.done);
        end
        clear = 1'b0;
        idleInputs();
        bus.select = 3'b011; bus.data_in = 8'hA6;
        tick();
        exp = 8'hA6;
        total++;
        if ({bus.data_out, bus.MSB_out, bus.LSB_out} !== {exp, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL load_a6 got data=%h msb=%b lsb=%b want a6/1/0", bus.data_out, bus.MSB_out, bus.LSB_out);
        end
    endtask

    task automatic test_rotr_burst();
        logic [9:0] want [4];
        want[0] = {8'h53, 1'b1, 1'b0};
        want[1] = {8'hA9, 1'b1, 1'b0};
        want[2] = {8'hD4, 1'b0, 1'b1};
        want[3] = {8'hD4, 1'b0, 1'b0};
        bus.start = 1'b1; bus.select = 3'b100; bus.count = 4'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            idleInputs();
            total++;
            if ({bus.data_out, bus.busy, bus.done} !== want[k]) begin
                bad++;
                $display("[TB] FAIL rotr_step%0d got=%h/%b/%b want=%h/%b/%b", k + 1,
                         bus.data_out, bus.busy, bus.done, want[k][9:2], want[k][1], want[k][0]);
            end
        end
        exp = 8'hD4;
    endtask

    task automatic test_shl_asr();
        logic [9:0] want [3];
        bus.select = 3'b011; bus.data_in = 8'h81;
        tick();
        bus.select = 3'b010; bus.LSB_in = 1'b1;
        tick();
        total++;
        if (bus.data_out !== 8'h03) begin
            bad++;
            $display("[TB] FAIL shl_direct got=%h want=03", bus.data_out);
        end
        bus.select = 3'b011; bus.data_in = 8'h90;
        tick();
        want[0] = {8'hC8, 1'b1, 1'b0};
        want[1] = {8'hE4, 1'b0, 1'b1};
        want[2] = {8'hE4, 1'b0, 1'b0};
        bus.start = 1'b1; bus.select = 3'b110; bus.count = 4'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            idleInputs();
            total++;
            if ({bus.data_out, bus.busy, bus.done} !== want[k]) begin
                bad++;
                $display("[TB] FAIL asr_step%0d got=%h/%b/%b want=%h/%b/%b", k + 1,
                         bus.data_out, bus.busy, bus.done, want[k][9:2], want[k][1], want[k][0]);
            end
        end
        exp = 8'hE4;
    endtask

    task automatic test_count_zero();
        exp = 8'($urandom);
        bus.select = 3'b011; bus.data_in = exp;
        tick();
        bus.start = 1'b1; bus.select = 3'b001; bus.count = 4'd0; bus.MSB_in = 1'b1;
        tick();
        idleInputs();
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== {exp, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL count_zero got=%h/%b/%b want=%h/0/1", bus.data_out, bus.busy, bus.done, exp);
        end
        tick();
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== {exp, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL count_zero_after got=%h/%b/%b want=%h/0/0", bus.data_out, bus.busy, bus.done, exp);
        end
    endtask

    task automatic test_random_direct();
        logic [2:0] m;
        logic [7:0] d;
        logic       mi, li;
        for (int i = 0; i < 40; i++) begin
            m = 3'($urandom); d = 8'($urandom); mi = 1'($urandom); li = 1'($urandom);
            bus.start = 1'b0; bus.select = m; bus.data_in = d; bus.MSB_in = mi; bus.LSB_in = li;
            bus.count = 4'($urandom);
            tick();
            exp = refStep(m, exp, mi, li, d);
            total++;
            if ({bus.data_out, bus.MSB_out, bus.LSB_out, bus.busy, bus.done} !== {exp, exp[7], exp[0], 2'b00}) begin
                bad++;
                $display("[TB] FAIL direct sel=%b got=%h msb=%b lsb=%b busy=%b done=%b want=%h", m,
                         bus.data_out, bus.MSB_out, bus.LSB_out, bus.busy, bus.done, exp);
            end
        end
    endtask

    // Random bursts; start, select, data_in and count are scrambled during
    // the burst and must have no effect on the step sequence.
    task automatic test_random_bursts();
        logic [2:0] modes [5];
        logic [2:0] m;
        int         n;
        logic       mi, li;
        modes[0] = 3'b001; modes[1] = 3'b010; modes[2] = 3'b100; modes[3] = 3'b101; modes[4] = 3'b110;
        for (int it = 0; it < 12; it++) begin
            exp = 8'($urandom);
            idleInputs();
            bus.select = 3'b011; bus.data_in = exp;
            tick();
            m = modes[$urandom_range(0, 4)];
            n = $urandom_range(1, 15);
            mi = 1'($urandom); li = 1'($urandom);
            bus.start = 1'b1; bus.select = m; bus.count = 4'(n); bus.MSB_in = mi; bus.LSB_in = li;
            for (int k = 1; k <= n; k++) begin
                tick();
                exp = refStep(m, exp, mi, li, 8'h00);
                total++;
                if ({bus.data_out, bus.busy, bus.done} !== {exp, (k < n), (k == n)}) begin
                    bad++;
                    $display("[TB] FAIL burst it=%0d sel=%b step=%0d/%0d got=%h/%b/%b want=%h/%b/%b", it, m, k, n,
                             bus.data_out, bus.busy, bus.done, exp, (k < n), (k == n));
                end
                mi = 1'($urandom); li = 1'($urandom);
                bus.MSB_in = mi; bus.LSB_in = li;
                bus.data_in = 8'($urandom);
                bus.count = 4'($urandom);
                if (k < n) begin
                    bus.start  = 1'($urandom);
                    bus.select = 3'($urandom);
                end else begin
                    idleInputs();
                end
            end
            tick();
            total++;
            if ({bus.data_out, bus.busy, bus.done} !== {exp, 2'b00}) begin
                bad++;
                $display("[TB] FAIL burst_end it=%0d got=%h/%b/%b want=%h/0/0", it, bus.data_out, bus.busy, bus.done, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        idleInputs();
        bus.select = 3'b011; bus.data_in = 8'h5A;
        tick();
        exp = 8'h5A;
        bus.start = 1'b1; bus.select = 3'b101; bus.count = 4'd2;
        tick();
        exp = refStep(3'b101, exp, 1'b0, 1'b0, 8'h00);
        bus.start = 1'b0;
        tick();
        exp = refStep(3'b101, exp, 1'b0, 1'b0, 8'h00);
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== {exp, 2'b01}) begin
            bad++;
            $display("[TB] FAIL b2b_first_done got=%h/%b/%b want=%h/0/1", bus.data_out, bus.busy, bus.done, exp);
        end
        bus.start = 1'b1; bus.select = 3'b001; bus.count = 4'd2; bus.MSB_in = 1'b1;
        tick();
        exp = refStep(3'b001, exp, 1'b1, 1'b0, 8'h00);
        bus.start = 1'b0; bus.MSB_in = 1'b0;
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== {exp, 2'b10}) begin
            bad++;
            $display("[TB] FAIL b2b_second_start got=%h/%b/%b want=%h/1/0", bus.data_out, bus.busy, bus.done, exp);
        end
        tick();
        exp = refStep(3'b001, exp, 1'b0, 1'b0, 8'h00);
        idleInputs();
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== {exp, 2'b01}) begin
            bad++;
            $display("[TB] FAIL b2b_second_done got=%h/%b/%b want=%h/0/1", bus.data_out, bus.busy, bus.done, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        idleInputs();
        bus.select = 3'b011; bus.data_in = 8'hFF;
        tick();
        exp = 8'hFF;
        bus.start = 1'b1; bus.select = 3'b010; bus.count = 4'd10; bus.LSB_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            bus.start = 1'b0;
            exp = refStep(3'b010, exp, 1'b0, 1'b0, 8'h00);
            total++;
            if ({bus.data_out, bus.busy, bus.done} !== {exp, 2'b10}) begin
                bad++;
                $display("[TB] FAIL midrst_step%0d got=%h/%b/%b want=%h/1/0", k, bus.data_out, bus.busy, bus.done, exp);
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idleInputs();
        total++;
        if ({bus.data_out, bus.busy, bus.done} !== 10'h000) begin
            bad++;
            $display("[TB] FAIL midrst_clear got=%h/%b/%b want=00/0/0", bus.data_out, bus.busy, bus.done);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if ({bus.data_out, bus.busy, bus.done} !== 10'h000) begin
                bad++;
                $display("[TB] FAIL midrst_quiet%0d got=%h/%b/%b want=00/0/0", k, bus.data_out, bus.busy, bus.done);
            end
        end
        bus.select = 3'b011; bus.data_in = 8'h3C;
        tick();
        bus.select = 3'b001; bus.MSB_in = 1'b1;
        tick();
        idleInputs();
        total++;
        if (bus.data_out !== 8'h9E) begin
            bad++;
            $display("[TB] FAIL midrst_resume got=%h want=9e", bus.data_out);
        end
        exp = 8'h9E;
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        logic [7:0] v [2];
        logic       want;
        v[0] = 8'hA6; v[1] = 8'hA7;
        for (int i = 0; i < 2; i++) begin
            bus.select = 3'b011; bus.data_in = v[i];
            tick();
            want = (i == 1);
            total++;
            if (bus.parity !== want) begin
                bad++;
                $display("[TB] FAIL parity load=%h got=%b want=%b", v[i], bus.parity, want);
            end
        end
        idleInputs();
    endtask
`endif

    initial begin
        clear = 1'b1;
        bus.data_in = '0; bus.MSB_in = 1'b0; bus.LSB_in = 1'b0;
        idleInputs();
        test_reset();
        test_rotr_burst();
        test_shl_asr();
        test_count_zero();
        test_random_direct();
        test_random_bursts();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
